// File: rtl/dmem_initiator_if.sv
// Bundle of the pipeline request/response handshake and the data-memory port.
// slave is the initiator block's view; master is the surrounding pipeline/memory view.
interface dmem_initiator_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_wr;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_trd;

  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic [2:0]  rsp_trd;
  logic        rsp_segfault;
  logic        rsp_timeout;

  logic [31:0] d_addr;
  logic [31:0] d_wr_data;
  logic        d_rd;
  logic        d_wr;
  logic [2:0]  d_trd;
  logic [31:0] d_rd_data;
  logic        d_miss;
  logic        d_segfault;

  modport slave (
    input  req_valid, req_wr, req_addr, req_wdata, req_trd,
    input  d_rd_data, d_miss, d_segfault,
    output req_ready,
    output rsp_valid, rsp_data, rsp_trd, rsp_segfault, rsp_timeout,
    output d_addr, d_wr_data, d_rd, d_wr, d_trd
  );

  modport master (
    output req_valid, req_wr, req_addr, req_wdata, req_trd,
    output d_rd_data, d_miss, d_segfault,
    input  req_ready,
    input  rsp_valid, rsp_data, rsp_trd, rsp_segfault, rsp_timeout,
    input  d_addr, d_wr_data, d_rd, d_wr, d_trd
  );
endinterface

// File: rtl/dmem_initiator.sv
// Data-memory initiator: issues one load/store, retries misses after a gap, reports result.
// Optional macro DMEM_MISALIGN_CHK_EN rejects word-misaligned addresses without touching memory.
module dmem_initiator #(
  parameter int RETRY_GAP = 4,
  parameter int RETRY_MAX = 7
) (
  input  logic             clk,
  input  logic             rst,
  dmem_initiator_if.slave  bus
);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, GAP, RESP} state_t;

  // Gap counter counts down to zero; a zero gap still spends one cycle in GAP.
  localparam logic [3:0] GAP_LOAD  = (RETRY_GAP > 1)  ? 4'(RETRY_GAP - 1) : 4'd0;
  localparam logic [3:0] RETRY_LIM = (RETRY_MAX > 15) ? 4'd15 : 4'(RETRY_MAX);

  state_t      state_q, state_d;
  logic        wr_q, wr_d;
  logic [3:0]  retry_q, retry_d;
  logic [3:0]  gap_q, gap_d;
  logic [31:0] d_addr_q, d_addr_d;
  logic [31:0] d_wr_data_q, d_wr_data_d;
  logic [2:0]  d_trd_q, d_trd_d;
  logic        d_rd_q, d_rd_d;
  logic        d_wr_q, d_wr_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_data_q, rsp_data_d;
  logic [2:0]  rsp_trd_q, rsp_trd_d;
  logic        rsp_seg_q, rsp_seg_d;
  logic        rsp_to_q, rsp_to_d;
  logic        misaligned;

`ifdef DMEM_MISALIGN_CHK_EN
  assign misaligned = (bus.req_addr[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    wr_d        = wr_q;
    retry_d     = retry_q;
    gap_d       = gap_q;
    d_addr_d    = d_addr_q;
    d_wr_data_d = d_wr_data_q;
    d_trd_d     = d_trd_q;
    d_rd_d      = 1'b0;
    d_wr_d      = 1'b0;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
    rsp_trd_d   = rsp_trd_q;
    rsp_seg_d   = rsp_seg_q;
    rsp_to_d    = rsp_to_q;

    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          wr_d    = bus.req_wr;
          retry_d = 4'd0;
          if (misaligned) begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_data_d  = 32'd0;
            rsp_trd_d   = bus.req_trd;
            rsp_seg_d   = 1'b1;
            rsp_to_d    = 1'b0;
          end else begin
            // The d_* registers double as the latched request for reissues.
            state_d     = ISSUE;
            d_addr_d    = bus.req_addr;
            d_wr_data_d = bus.req_wdata;
            d_trd_d     = bus.req_trd;
            d_rd_d      = ~bus.req_wr;
            d_wr_d      = bus.req_wr;
          end
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (bus.d_segfault) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_data_d  = 32'd0;
          rsp_trd_d   = d_trd_q;
          rsp_seg_d   = 1'b1;
          rsp_to_d    = 1'b0;
        end else if (bus.d_miss && (retry_q < RETRY_LIM)) begin
          state_d = GAP;
          retry_d = (retry_q == 4'hF) ? retry_q : retry_q + 4'd1;
          gap_d   = GAP_LOAD;
        end else begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_trd_d   = d_trd_q;
          rsp_seg_d   = 1'b0;
          rsp_to_d    = bus.d_miss;
          rsp_data_d  = (bus.d_miss || wr_q) ? 32'd0 : bus.d_rd_data;
        end
      end
      GAP: begin
        if (gap_q == 4'd0) begin
          state_d = ISSUE;
          d_rd_d  = ~wr_q;
          d_wr_d  = wr_q;
        end else begin
          gap_d = gap_q - 4'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      wr_q        <= 1'b0;
      retry_q     <= 4'd0;
      gap_q       <= 4'd0;
      d_addr_q    <= 32'd0;
      d_wr_data_q <= 32'd0;
      d_trd_q     <= 3'd0;
      d_rd_q      <= 1'b0;
      d_wr_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 32'd0;
      rsp_trd_q   <= 3'd0;
      rsp_seg_q   <= 1'b0;
      rsp_to_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_q        <= wr_d;
      retry_q     <= retry_d;
      gap_q       <= gap_d;
      d_addr_q    <= d_addr_d;
      d_wr_data_q <= d_wr_data_d;
      d_trd_q     <= d_trd_d;
      d_rd_q      <= d_rd_d;
      d_wr_q      <= d_wr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_trd_q   <= rsp_trd_d;
      rsp_seg_q   <= rsp_seg_d;
      rsp_to_q    <= rsp_to_d;
    end
  end

  assign bus.req_ready    = (state_q == IDLE);
  assign bus.d_addr       = d_addr_q;
  assign bus.d_wr_data    = d_wr_data_q;
  assign bus.d_trd        = d_trd_q;
  assign bus.d_rd         = d_rd_q;
  assign bus.d_wr         = d_wr_q;
  assign bus.rsp_valid    = rsp_valid_q;
  assign bus.rsp_data     = rsp_data_q;
  assign bus.rsp_trd      = rsp_trd_q;
  assign bus.rsp_segfault = rsp_seg_q;
  assign bus.rsp_timeout  = rsp_to_q;

endmodule

// File: tb/tb_dmem_initiator.sv
// Bench for dmem_initiator: directed vector table, reset corner cases, random traffic vs. a transaction model.
module tb_dmem_initiator;
  localparam int GAP  = 4;
  localparam int RMAX = 7;
  localparam int GAPC = (GAP > 0) ? GAP : 1;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  dmem_initiator_if bus();
  dmem_initiator #(.RETRY_GAP(GAP), .RETRY_MAX(RMAX)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic miss; logic seg; logic [31:0] data; } outc_t;
  typedef struct { int cyc; logic rd; logic wr; logic [31:0] addr; logic [31:0] wdata; logic [2:0] trd; } iss_t;
  typedef struct { int cyc; logic [31:0] data; logic [2:0] trd; logic seg; logic to; } rsp_t;
  typedef struct { int n; logic [31:0] data; logic seg; logic to; int lat; } exp_t;
  typedef struct {
    logic wr; logic [31:0] addr; logic [31:0] wdata; logic [2:0] trd;
    int nmiss; logic fseg; logic [31:0] rdata;
    int n; logic [31:0] data; logic seg; logic to; int lat;
  } vec_t;

  outc_t outq[$];
  iss_t  iss_q[$];
  rsp_t  rsp_q[$];

  // Monitor: record every memory access cycle and every response strobe.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.d_rd || bus.d_wr)
        iss_q.push_back('{cyc, bus.d_rd, bus.d_wr, bus.d_addr, bus.d_wr_data, bus.d_trd});
      if (bus.rsp_valid)
        rsp_q.push_back('{cyc, bus.rsp_data, bus.rsp_trd, bus.rsp_segfault, bus.rsp_timeout});
    end
  end

  // Memory: answers in the cycle after an access using the next scripted outcome.
  initial begin
    logic pend;
    outc_t o;
    bus.d_miss = 1'b0; bus.d_segfault = 1'b0; bus.d_rd_data = 32'd0;
    forever begin
      @(negedge clk);
      pend = bus.d_rd | bus.d_wr;
      @(posedge clk);
      #1;
      if (pend && outq.size() > 0) begin
        o = outq.pop_front();
        bus.d_miss = o.miss; bus.d_segfault = o.seg; bus.d_rd_data = o.data;
      end else begin
        bus.d_miss = 1'b0; bus.d_segfault = 1'b0; bus.d_rd_data = $urandom;
      end
    end
  end

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: walk the scripted outcomes access by access.
  function automatic exp_t model(input logic wr, input logic misal, input outc_t oc[$]);
    exp_t e;
    e = '{0, 32'd0, 1'b0, 1'b0, 0};
    if (misal) begin
      e.seg = 1'b1; e.lat = 1;
      return e;
    end
    for (int k = 0; k <= RMAX; k++) begin
      outc_t o;
      o = (k < oc.size()) ? oc[k] : '{1'b0, 1'b0, 32'd0};
      e.n = k + 1;
      if (o.seg) begin e.seg = 1'b1; break; end
      if (o.miss) begin
        if (k < RMAX) continue;
        e.to = 1'b1; break;
      end
      e.data = wr ? 32'd0 : o.data;
      break;
    end
    e.lat = 1 + 2 * e.n + (e.n - 1) * GAPC;
    return e;
  endfunction

  task automatic send(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [2:0] trd, output int t);
    int n;
    t = -1; n = 0;
    @(posedge clk); #1;
    bus.req_valid = 1'b1; bus.req_wr = wr; bus.req_addr = addr;
    bus.req_wdata = wdata; bus.req_trd = trd;
    while (n < 200) begin
      @(negedge clk);
      if (bus.req_ready) begin t = cyc; break; end
      n++;
    end
    @(posedge clk); #1;
    bus.req_valid = 1'b0; bus.req_addr = $urandom; bus.req_wdata = $urandom;
    if (t < 0) begin
      checks++; errors++;
      $display("FAIL handshake: req_ready never seen within 200 cycles");
    end
  endtask

  task automatic run_txn(input string tag, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [2:0] trd,
                         input outc_t oc[$], input exp_t e);
    int t, n;
    rsp_t r;
    outq = oc; iss_q.delete(); rsp_q.delete();
    send(wr, addr, wdata, trd, t);
    if (t < 0) return;
    n = 0;
    while (rsp_q.size() == 0 && n < 400) begin @(negedge clk); n++; end
    if (rsp_q.size() == 0) begin
      checks++; errors++;
      $display("FAIL %s rsp_timeout_wait: no rsp_valid within 400 cycles", tag);
      return;
    end
    r = rsp_q.pop_front();
    chk({tag, " latency"}, 96'(r.cyc - t), 96'(e.lat));
    chk({tag, " rsp_data"}, 96'(r.data), 96'(e.data));
    chk({tag, " rsp_trd"}, 96'(r.trd), 96'(trd));
    chk({tag, " flags"}, 96'({r.seg, r.to}), 96'({e.seg, e.to}));
    @(negedge clk); @(negedge clk);
    chk({tag, " extra_rsp"}, 96'(rsp_q.size()), 96'd0);
    chk({tag, " access_count"}, 96'(iss_q.size()), 96'(e.n));
    foreach (iss_q[k]) begin
      chk({tag, " access_cycle"}, 96'(iss_q[k].cyc - t), 96'(1 + k * (2 + GAPC)));
      chk({tag, " access_fields"},
          {27'd0, iss_q[k].rd, iss_q[k].wr, iss_q[k].addr, iss_q[k].wdata, iss_q[k].trd},
          {27'd0, ~wr, wr, addr, wdata, trd});
    end
    if (e.n > 0) chk({tag, " d_addr_hold"}, 96'(bus.d_addr), 96'(addr));
    $display("txn %s wr=%0d addr=%h trd=%0d -> data=%h seg=%0d to=%0d", tag, wr, addr, trd, r.data, r.seg, r.to);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t  vecs[$];
    outc_t oc[$];
    exp_t  e;
    int    t;

    vecs.push_back('{1'b0, 32'h00010104, 32'h0, 3'd2, 0, 1'b0, 32'hDEADBEEF, 1, 32'hDEADBEEF, 1'b0, 1'b0, 3});
    vecs.push_back('{1'b1, 32'h00010200, 32'h12345678, 3'd0, 0, 1'b0, 32'hFFFF0000, 1, 32'h0, 1'b0, 1'b0, 3});
    vecs.push_back('{1'b0, 32'h00020010, 32'h0, 3'd5, 2, 1'b0, 32'hCAFEF00D, 3, 32'hCAFEF00D, 1'b0, 1'b0, 15});
    vecs.push_back('{1'b0, 32'h00030000, 32'h0, 3'd7, 8, 1'b0, 32'h11111111, 8, 32'h0, 1'b0, 1'b1, 45});
    vecs.push_back('{1'b0, 32'h00040008, 32'h0, 3'd3, 0, 1'b1, 32'h55AA55AA, 1, 32'h0, 1'b1, 1'b0, 3});
    vecs.push_back('{1'b1, 32'h00050004, 32'hA5A5A5A5, 3'd6, 2, 1'b1, 32'h0, 3, 32'h0, 1'b1, 1'b0, 15});
    vecs.push_back('{1'b1, 32'h00060000, 32'h0BADF00D, 3'd1, 1, 1'b0, 32'h77777777, 2, 32'h0, 1'b0, 1'b0, 9});
`ifdef DMEM_MISALIGN_CHK_EN
    vecs.push_back('{1'b0, 32'h00010102, 32'h0, 3'd4, 0, 1'b0, 32'h12121212, 0, 32'h0, 1'b1, 1'b0, 1});
`else
    vecs.push_back('{1'b0, 32'h00010102, 32'h0, 3'd4, 0, 1'b0, 32'h12121212, 1, 32'h12121212, 1'b0, 1'b0, 3});
`endif

    rst = 1'b1;
    bus.req_valid = 1'b0; bus.req_wr = 1'b0; bus.req_addr = 32'd0;
    bus.req_wdata = 32'd0; bus.req_trd = 3'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_hold req_ready", 96'(bus.req_ready), 96'd1);
    chk("reset_hold rsp_valid", 96'(bus.rsp_valid), 96'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("reset req_ready", 96'(bus.req_ready), 96'd1);
    chk("reset rsp", {58'd0, bus.rsp_valid, bus.rsp_data, bus.rsp_trd, bus.rsp_segfault, bus.rsp_timeout}, 96'd0);
    chk("reset d_port", {25'd0, bus.d_rd, bus.d_wr, bus.d_addr, bus.d_wr_data, bus.d_trd}, 96'd0);

    foreach (vecs[i]) begin
      oc.delete();
      for (int k = 0; k < vecs[i].nmiss; k++) oc.push_back('{1'b1, 1'b0, 32'h0});
      if (vecs[i].fseg) oc.push_back('{1'b1, 1'b1, vecs[i].rdata});
      else              oc.push_back('{1'b0, 1'b0, vecs[i].rdata});
      e = '{vecs[i].n, vecs[i].data, vecs[i].seg, vecs[i].to, vecs[i].lat};
      run_txn($sformatf("vec%0d", i), vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].trd, oc, e);
    end

    // Reset in the middle of the retry gap aborts the request silently.
    oc.delete();
    for (int k = 0; k < 20; k++) oc.push_back('{1'b1, 1'b0, 32'h0});
    outq = oc; iss_q.delete(); rsp_q.delete();
    send(1'b0, 32'h00070000, 32'h0, 3'd1, t);
    if (t >= 0) begin
      while (cyc < t + 4) @(negedge clk);
      @(posedge clk); #1; rst = 1'b1;
      @(posedge clk); #1; rst = 1'b0;
      @(negedge clk);
      chk("gap_reset req_ready", 96'(bus.req_ready), 96'd1);
      repeat (20) @(negedge clk);
      chk("gap_reset accesses", 96'(iss_q.size()), 96'd1);
      chk("gap_reset no_rsp", 96'(rsp_q.size()), 96'd0);
      $display("txn gap_reset addr=00070000 aborted");
    end
    outq.delete();

    for (int i = 0; i < 40; i++) begin
      logic        wr, misal;
      logic [31:0] addr;
      wr = 1'($urandom_range(0, 1));
      addr = $urandom;
`ifdef DMEM_MISALIGN_CHK_EN
      if ($urandom_range(0, 5) != 0) addr[1:0] = 2'b00;
      misal = (addr[1:0] != 2'b00);
`else
      misal = 1'b0;
`endif
      oc.delete();
      for (int k = 0; k <= RMAX; k++)
        oc.push_back('{($urandom_range(0, 2) == 0), ($urandom_range(0, 9) == 0), $urandom});
      e = model(wr, misal, oc);
      run_txn($sformatf("rnd%0d", i), wr, addr, $urandom, 3'($urandom_range(0, 7)), oc, e);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/dmem_initiator.md
DMEM_INITIATOR -- requirements
Module: dmem_initiator

Interface
REQ-001 Parameter RETRY_GAP, default 4: idle cycles between a missed access and its reissue (range 0..15).
REQ-002 Parameter RETRY_MAX, default 7: maximum reissues per request before a timeout response.
REQ-003 clk  in  1  sole clock; all state changes on rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 req_valid  in  1  pipeline load/store request valid.
REQ-006 req_ready  out  1  block can accept a request.
REQ-007 req_wr  in  1  1 = store, 0 = load.
REQ-008 req_addr  in  32  byte address.
REQ-009 req_wdata  in  32  store data.
REQ-010 req_trd  in  3  issuing thread id.
REQ-011 rsp_valid  out  1  one-cycle response strobe.
REQ-012 rsp_data  out  32  load data; 0 for stores and faults.
REQ-013 rsp_trd  out  3  thread id of the completed request.
REQ-014 rsp_segfault  out  1  memory reported a segfault.
REQ-015 rsp_timeout  out  1  retry budget exhausted.
REQ-016 d_addr, d_wr_data (out 32), d_rd, d_wr (out 1), d_trd (out 3)  data-memory request.
REQ-017 d_rd_data (in 32), d_miss, d_segfault (in 1)  memory response, valid the cycle after d_rd/d_wr.

Function
REQ-018 FSM states: IDLE, ISSUE, WAIT, GAP, RESP.
- req_ready = 1 only in IDLE.
- A handshake (req_valid & req_ready) latches addr, wdata, wr and trd, clears the retry count, and goes to ISSUE.
REQ-019 ISSUE:
- Exactly one of d_rd/d_wr is high for exactly one cycle.
- d_addr, d_wr_data and d_trd come from latched values.
- Next state is WAIT.
REQ-020 Outside ISSUE:
- d_rd = d_wr = 0.
- d_addr, d_wr_data and d_trd hold their last values.
REQ-021 WAIT samples d_segfault, d_miss and d_rd_data.
- Segfault has priority: d_segfault = 1 goes to RESP with rsp_segfault = 1, regardless of d_miss.
REQ-022 WAIT with d_miss = 1 and d_segfault = 0:
- Retry count < RETRY_MAX: increment the count and go to GAP.
- Otherwise: go to RESP with rsp_timeout = 1.
REQ-023 GAP waits RETRY_GAP cycles, then goes to ISSUE. RETRY_GAP = 0 goes to ISSUE after one cycle.
REQ-024 WAIT with no miss and no segfault goes to RESP.
- rsp_data captures d_rd_data for loads and 0 for stores.
REQ-025 RESP holds rsp_valid = 1 for one cycle with rsp_trd = latched thread, then returns to IDLE.
REQ-026 rsp_data, rsp_segfault and rsp_timeout hold their values until the next RESP. rsp_data = 0 whenever either fault flag is set.
REQ-027 No-miss latency: handshake at cycle T gives d_rd/d_wr at T+1 and rsp_valid at T+3.
- Throughput is one request per 4 cycles.
REQ-028 The retry counter is 4 bits and saturates; it never wraps.

Reset
REQ-029 While rst is high and on the following edge, the block enters IDLE and clears all outputs, latched fields and counters.
REQ-030 Reset during any non-IDLE state aborts the request. No rsp_valid is ever produced for the aborted request.

Configuration
REQ-031 Macro DMEM_MISALIGN_CHK_EN.
- Defined: a handshake with req_addr[1:0] != 0 skips ISSUE and goes straight to RESP. Memory is not accessed; rsp_segfault = 1 and rsp_valid is asserted at T+1.
- Undefined: no alignment check; the address passes to d_addr unchanged.

Verification
REQ-032 Load from addr 0x00010104, thread 2, memory returns 0xDEADBEEF -> d_rd at T+1; rsp_valid at T+3 with rsp_data 0xDEADBEEF, rsp_trd 2, both flags 0.
REQ-033 Store of 0x12345678 to 0x00010200, thread 0 -> d_wr is a one-cycle pulse with d_wr_data 0x12345678; rsp_data 0; no flags.
REQ-034 d_miss on 2 consecutive accesses with RETRY_GAP = 4 -> 3 d_rd pulses spaced 6 cycles apart; final response is normal.
REQ-035 d_miss on every access with RETRY_MAX = 7 -> 8 d_rd pulses, then rsp_timeout = 1 and rsp_data = 0.
REQ-036 d_miss = 1 and d_segfault = 1 in the same cycle -> no retry; rsp_segfault = 1. With DMEM_MISALIGN_CHK_EN, addr 0x00010102 -> no d_rd, rsp_segfault = 1 at T+1.
REQ-037 rst asserted during GAP -> no further d_rd, no rsp_valid; req_ready = 1 on the cycle after rst deasserts.
